pipe_hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the five-stage RV32I core.
- Decides each cycle whether each pipeline register advances, holds, or is loaded with a bubble. Causes: load-use RAW, taken branch/jump, multi-cycle data-memory wait, halt drain.
- Replaces the per-stage bubble logic with one FSM plus counters. Sits beside the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 43 ++++
 rtl/hazard_src_use.sv | 14 +
 rtl/pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: opcodes, FSM encoding
// and the per-cycle pipeline control word.
package pipe_hazard_ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_HALT  = 7'b1111111;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  // Halt needs three more edges to walk EX -> MEM -> WB.
  localparam int                 DRAIN_W   = 2;
  localparam logic [DRAIN_W-1:0] DRAIN_CNT = 2'd3;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_bubble;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN      = 7'b1111_000;
  localparam ctrl_t CTRL_MEMSTALL = 7'b0000_001;
  localparam ctrl_t CTRL_BRANCH   = 7'b1111_110;
  localparam ctrl_t CTRL_LOADUSE  = 7'b0011_010;
  localparam ctrl_t CTRL_HALTID   = 7'b0011_000;
  localparam ctrl_t CTRL_DRAIN    = 7'b0011_010;
  localparam ctrl_t CTRL_FROZEN   = 7'b0000_111;

endpackage

// File: rtl/hazard_src_use.sv
// Opcode -> source-register usage decode. Purely combinational; shared with
// the forwarding unit so both agree on which rs fields are real.
module hazard_src_use
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic       uses_rs1,
  output logic       uses_rs2
);

  assign uses_rs1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  assign uses_rs2 = (op == OP_R) || (op == OP_B) || (op == OP_S);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central advance/hold/bubble sequencer for the five-stage pipeline.
// Optional PIPE_PERF_CNT_EN adds saturating stall/flush/wait counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       id_valid,
  input  logic [6:0] id_op,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic [6:0] ex_op,
  input  logic [4:0] ex_rd,
  input  logic       ex_br_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       mem_wb_bubble,
  output logic       halted,
  output logic       mem_timeout
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
`endif
);

  state_e              state_q, state_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [WAIT_W-1:0]   wait_q, wait_d, wait_inc;
  logic                timeout_q, timeout_d;
  ctrl_t               ctrl;

  logic uses_rs1, uses_rs2;
  logic loaduse, memstall, halt_id;

  hazard_src_use u_src_use (
    .op       (id_op),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign loaduse = ex_valid && (ex_op == OP_LOAD) && (ex_rd != 5'd0) && id_valid &&
                   ((uses_rs1 && (id_rs1 == ex_rd)) || (uses_rs2 && (id_rs2 == ex_rd)));
  assign memstall = mem_req && !mem_ready;
  assign halt_id  = id_valid && (id_op == OP_HALT);
  assign wait_inc = (&wait_q) ? wait_q : wait_q + 1'b1;

  // Mealy decode: a stall must act in the same cycle it is detected.
  always_comb begin
    ctrl    = CTRL_RUN;
    state_d = state_q;
    drain_d = drain_q;
    wait_d  = '0;
    unique case (state_q)
      ST_RUN, ST_MEMWAIT: begin
        if (memstall) begin
          ctrl    = CTRL_MEMSTALL;
          state_d = ST_MEMWAIT;
          wait_d  = wait_inc;
        end else begin
          state_d = ST_RUN;
          // Branch first: whatever sits in ID is wrong-path.
          if (ex_br_taken) begin
            ctrl = CTRL_BRANCH;
          end else if (loaduse) begin
            ctrl = CTRL_LOADUSE;
          end else if (halt_id) begin
            ctrl    = CTRL_HALTID;
            state_d = ST_DRAIN;
            drain_d = DRAIN_CNT;
          end
        end
      end
      ST_DRAIN: begin
        if (memstall) begin
          ctrl   = CTRL_MEMSTALL;
          wait_d = wait_inc;
        end else begin
          ctrl    = CTRL_DRAIN;
          drain_d = drain_q - 1'b1;
          if (drain_q <= DRAIN_W'(1)) state_d = ST_HALT;
        end
      end
      default: ctrl = CTRL_FROZEN;
    endcase
    timeout_d = timeout_q || (wait_d == WAIT_W'(MAX_WAIT));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_RUN;
      drain_q   <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Reset forces the safe pattern combinationally, without waiting for CLK.
  assign pc_en         = ctrl.pc_en         && !RST;
  assign if_id_en      = ctrl.if_id_en      && !RST;
  assign id_ex_en      = ctrl.id_ex_en      && !RST;
  assign ex_mem_en     = ctrl.ex_mem_en     && !RST;
  assign if_id_flush   = ctrl.if_id_flush   || RST;
  assign id_ex_bubble  = ctrl.id_ex_bubble  || RST;
  assign mem_wb_bubble = ctrl.mem_wb_bubble || RST;
  assign halted        = (state_q == ST_HALT) && !RST;
  assign mem_timeout   = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic             run_dec, lu_ev, br_ev, wait_ev;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q,  wait_cnt_d;

  assign run_dec = ((state_q == ST_RUN) || (state_q == ST_MEMWAIT)) && !memstall;
  assign br_ev   = run_dec && ex_br_taken;
  assign lu_ev   = run_dec && !ex_br_taken && loaduse;
  assign wait_ev = (state_q == ST_MEMWAIT);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (lu_ev   && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (br_ev   && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    if (wait_ev && !(&wait_cnt_q))  wait_cnt_d  = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes hand-computed control
// words, a monitor pops and compares them mid-cycle.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] HLT  = 7'b1111111;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble, mem_wb_bubble, halted, mem_timeout}
  localparam logic [8:0] E_RUN = 9'b1111_000_00;
  localparam logic [8:0] E_MS  = 9'b0000_001_00;
  localparam logic [8:0] E_LU  = 9'b0011_010_00;
  localparam logic [8:0] E_BR  = 9'b1111_110_00;
  localparam logic [8:0] E_HID = 9'b0011_000_00;
  localparam logic [8:0] E_DRN = 9'b0011_010_00;
  localparam logic [8:0] E_HLT = 9'b0000_111_10;
  localparam logic [8:0] E_RST = 9'b0000_111_00;
  localparam logic [8:0] T     = 9'b0000_000_01;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       id_valid = 1'b0, ex_valid = 1'b0, ex_br_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b0;
  logic [6:0] id_op = '0, ex_op = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic       if_id_flush, id_ex_bubble, mem_wb_bubble, halted, mem_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  pipe_hazard_ctrl dut (
    .CLK(CLK), .RST(RST),
    .id_valid(id_valid), .id_op(id_op), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .mem_wb_bubble(mem_wb_bubble),
    .halted(halted), .mem_timeout(mem_timeout)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      nm;
    logic [8:0] v;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  int         checks = 0;
  int         errors = 0;
  logic [8:0] got;

  assign got = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble,
                mem_wb_bubble, halted, mem_timeout};

  // Monitor: every cycle with a pending expectation, compare away from edges.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if (sb.size() != 0) begin
        cur = sb.pop_front();
        checks++;
        if (got !== cur.v) begin
          errors++;
          $display("FAIL %s: got %b expected %b", cur.nm, got, cur.v);
        end
      end
    end
  end

  task automatic cyc(input string nm, input logic rst,
                     input logic iv, input logic [6:0] iop, input logic [4:0] r1, input logic [4:0] r2,
                     input logic ev, input logic [6:0] eop, input logic [4:0] erd,
                     input logic br, input logic mreq, input logic mrdy, input logic [8:0] e);
    @(negedge CLK);
    RST = rst;
    id_valid = iv; id_op = iop; id_rs1 = r1; id_rs2 = r2;
    ex_valid = ev; ex_op = eop; ex_rd = erd; ex_br_taken = br;
    mem_req = mreq; mem_ready = mrdy;
    sb.push_back('{nm, e});
  endtask

  task automatic idle(input string nm, input logic rst, input logic [8:0] e);
    cyc(nm, rst, 0, ADD, 0, 0, 0, ADD, 0, 0, 0, 0, e);
  endtask

  // Raise RST between clock edges; inputs stay as the previous cycle left them.
  task automatic async_rst(input string nm);
    @(negedge CLK);
    sb.push_back('{nm, E_RST});
    #1 RST = 1'b1;
  endtask

  initial begin
    #1 RST = 1'b1;
    idle("reset_a", 1, E_RST);
    idle("reset_b", 1, E_RST);
    idle("run_idle", 0, E_RUN);

    // Load-use and the cases that must not stall
    cyc("loaduse_rs1",  0, 1, ADD,  5, 7, 1, LW,  5, 0, 0, 0, E_LU);
    cyc("after_bubble", 0, 1, ADD,  5, 7, 0, ADD, 0, 0, 0, 0, E_RUN);
    cyc("loaduse_rs2",  0, 1, ADD,  1, 7, 1, LW,  7, 0, 0, 0, E_LU);
    cyc("rd_zero",      0, 1, ADD,  0, 2, 1, LW,  0, 0, 0, 0, E_RUN);
    cyc("addi_rs2",     0, 1, ADDI, 8, 5, 1, LW,  5, 0, 0, 0, E_RUN);
    cyc("lui_rs1",      0, 1, LUI,  5, 5, 1, LW,  5, 0, 0, 0, E_RUN);
    cyc("id_invalid",   0, 0, ADD,  5, 5, 1, LW,  5, 0, 0, 0, E_RUN);
    cyc("nonload_ex",   0, 1, ADD,  5, 5, 1, ADD, 5, 0, 0, 0, E_RUN);

    // Branch beats load-use and halt in ID
    cyc("br_vs_lu",     0, 1, ADD,  5, 7, 1, LW,  5, 1, 0, 0, E_BR);
    cyc("br_vs_halt",   0, 1, HLT,  0, 0, 0, ADD, 0, 1, 0, 0, E_BR);

    // Three wait cycles with a load-use pending; exit cycle runs the RUN decode
    for (int k = 1; k <= 3; k++)
      cyc($sformatf("memwait3_c%0d", k), 0, 1, ADD, 5, 7, 1, LW, 5, 0, 1, 0, E_MS);
    cyc("memwait3_exit", 0, 1, ADD, 5, 7, 1, LW, 5, 0, 1, 1, E_LU);
    idle("memwait3_after", 0, E_RUN);

    // Long wait: timeout visible once 15 wait cycles have elapsed
    for (int k = 1; k <= 16; k++)
      cyc($sformatf("memwait16_c%0d", k), 0, 0, ADD, 0, 0, 0, ADD, 0, 0, 1, 0,
          (k == 16) ? (E_MS | T) : E_MS);
    cyc("memwait16_exit", 0, 0, ADD, 0, 0, 0, ADD, 0, 0, 1, 1, E_RUN | T);
    idle("timeout_sticky", 0, E_RUN | T);

    // Halt: drain three cycles, then halted stays up; memory inputs ignored
    cyc("halt_id", 0, 1, HLT, 0, 0, 0, ADD, 0, 0, 0, 0, E_HID | T);
    for (int k = 1; k <= 3; k++)
      cyc($sformatf("drain_c%0d", k), 0, 1, HLT, 0, 0, 0, ADD, 0, 0, 0, 0, E_DRN | T);
    for (int k = 0; k < 11; k++)
      cyc($sformatf("halted_c%0d", k), 0, 1, HLT, 0, 0, 0, ADD, 0, 1, 1, k[0], E_HLT | T);
    idle("halt_rst", 1, E_RST);
    idle("halt_rst_release", 0, E_RUN);

    // Memory stall inside drain freezes the count
    cyc("halt2_id", 0, 1, HLT, 0, 0, 0, ADD, 0, 0, 0, 0, E_HID);
    cyc("drain2_c1", 0, 1, HLT, 0, 0, 0, ADD, 0, 0, 0, 0, E_DRN);
    cyc("drain2_ms", 0, 1, HLT, 0, 0, 0, ADD, 0, 0, 1, 0, E_MS);
    cyc("drain2_c2", 0, 1, HLT, 0, 0, 0, ADD, 0, 0, 0, 0, E_DRN);
    cyc("drain2_c3", 0, 1, HLT, 0, 0, 0, ADD, 0, 0, 0, 0, E_DRN);
    cyc("halted2",   0, 1, HLT, 0, 0, 0, ADD, 0, 0, 0, 0, E_HLT);
    idle("halt2_rst", 1, E_RST);
    idle("halt2_release", 0, E_RUN);

    // Async reset mid-drain discards the drain count
    cyc("halt3_id", 0, 1, HLT, 0, 0, 0, ADD, 0, 0, 0, 0, E_HID);
    cyc("drain3_c1", 0, 1, HLT, 0, 0, 0, ADD, 0, 0, 0, 0, E_DRN);
    async_rst("async_rst_drain");
    idle("after_rst_drain", 0, E_RUN);

    // Async reset mid-MEMWAIT clears the sticky timeout
    for (int k = 1; k <= 16; k++)
      cyc($sformatf("memwait_b_c%0d", k), 0, 0, ADD, 0, 0, 0, ADD, 0, 0, 1, 0,
          (k == 16) ? (E_MS | T) : E_MS);
    async_rst("async_rst_memwait");
    idle("after_rst_memwait", 0, E_RUN);
    idle("final_idle", 0, E_RUN);

    @(negedge CLK);
    #4;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
